poly_music_core: RTL and testbench

//   Parametrised playback core for the multi-voice player: play/pause/next song control, beat

---
 rtl/poly_music_core_pkg.sv | 17 +
 rtl/poly_music_core_sample_mixer.sv | 69 ++++++
 rtl/poly_music_core.sv | 170 +++++++++++++++++
 tb/tb_poly_music_core.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/poly_music_core_pkg.sv
// Shared definitions for the multi-voice playback core.
//   ctrl_state_t : control FSM encodings (values match the legacy encodings)
//   GAIN_*       : per-voice gain codes carried on voice_gain
package poly_music_core_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_PLAYING = 2'd1,
        ST_ADVANCE = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] GAIN_MUTE = 2'd0;
    localparam logic [1:0] GAIN_QTR  = 2'd1;
    localparam logic [1:0] GAIN_HALF = 2'd2;
    localparam logic [1:0] GAIN_FULL = 2'd3;

endpackage

// File: rtl/poly_music_core_sample_mixer.sv
// sample_mixer: applies a per-voice gain shift, sums all voices in a widened
// accumulator, saturates to the sample range and registers the result.
//   clk, reset     : clock, asynchronous active-high reset
//   voice_samples  : NUM_VOICES signed samples, voice v at [v*SAMPLE_W +: SAMPLE_W]
//   voice_gain     : NUM_VOICES 2-bit gain codes, voice v at [v*2 +: 2]
//   sample_ready   : load the mixed result into pending this cycle
//   pending        : registered saturated mix (held until the next sample_ready)
module sample_mixer
    import poly_music_core_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_W   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic [NUM_VOICES*2-1:0]        voice_gain,
    input  logic                           sample_ready,
    output logic [SAMPLE_W-1:0]            pending
);

    localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES);

    // Sample range limits expressed in the wide accumulator width.
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    logic signed [SAMPLE_W-1:0] voice_x;
    logic signed [SAMPLE_W-1:0] scaled;
    logic signed [SUM_W-1:0]    sum;
    logic        [SAMPLE_W-1:0] mixed;

    always_comb begin
        sum     = '0;
        voice_x = '0;
        scaled  = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            voice_x = voice_samples[v*SAMPLE_W +: SAMPLE_W];
            case (voice_gain[v*2 +: 2])
                GAIN_QTR:  scaled = voice_x >>> 2;
                GAIN_HALF: scaled = voice_x >>> 1;
                GAIN_FULL: scaled = voice_x;
                default:   scaled = '0;
            endcase
            sum = sum + SUM_W'(scaled);
        end
    end

    always_comb begin
        if (sum > SAT_MAX) begin
            mixed = SAT_MAX[SAMPLE_W-1:0];
        end else if (sum < SAT_MIN) begin
            mixed = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            mixed = sum[SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (sample_ready) begin
            pending <= mixed;
        end
    end

endmodule

// File: rtl/poly_music_core.sv
// poly_music_core: playback core for the multi-voice player. Play/pause/next
// control FSM, codec frame sync, pause-gated beat generation, weighted voice
// mixing (via sample_mixer) and a one-deep output buffer with underrun report.
//   clk, reset           : clock, asynchronous active-high reset
//   play_button          : one-pulse, toggle play/pause
//   next_button          : one-pulse, advance to the next song
//   song_done            : song reader reached end of song (acted on while playing)
//   new_frame            : raw codec frame strobe (level)
//   voice_samples        : signed voice samples, voice v at [v*SAMPLE_W +: SAMPLE_W]
//   voice_gain           : 2-bit gain code per voice
//   sample_ready         : voice_samples valid this cycle
//   play                 : 1 while playing
//   current_song         : selected song index
//   reset_player         : one-cycle pulse resetting the song reader
//   beat                 : one-cycle beat pulse
//   generate_next_sample : one-cycle pulse per codec frame
//   sample_out           : sample to codec, stable between frames
//   underrun             : one-cycle pulse when a frame found no new mix
module poly_music_core
    import poly_music_core_pkg::*;
#(
    parameter int NUM_SONGS  = 4,
    parameter int SONG_W     = 2,
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_W   = 16,
    parameter int BEAT_COUNT = 1000,
    parameter int BEAT_W     = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play_button,
    input  logic                           next_button,
    input  logic                           song_done,
    input  logic                           new_frame,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic [NUM_VOICES*2-1:0]        voice_gain,
    input  logic                           sample_ready,
    output logic                           play,
    output logic [SONG_W-1:0]              current_song,
    output logic                           reset_player,
    output logic                           beat,
    output logic                           generate_next_sample,
    output logic [SAMPLE_W-1:0]            sample_out,
    output logic                           underrun
);

    ctrl_state_t         state;
    ctrl_state_t         next_state;
    logic                new_frame_d;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                valid;
    logic [SAMPLE_W-1:0] pending;

    // ---------------- control FSM ----------------
    always_comb begin
        next_state = state;
        case (state)
            ST_PAUSED: begin
                if (next_button) begin
                    next_state = ST_ADVANCE;
                end else if (play_button) begin
                    next_state = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                if (next_button || song_done) begin
                    next_state = ST_ADVANCE;
                end else if (play_button) begin
                    next_state = ST_PAUSED;
                end
            end
            ST_ADVANCE: next_state = ST_PAUSED;
            default:    next_state = ST_PAUSED;
        endcase
    end

    // play and reset_player are registered from next_state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_PAUSED;
            play         <= 1'b0;
            reset_player <= 1'b0;
            current_song <= '0;
        end else begin
            state        <= next_state;
            play         <= (next_state == ST_PLAYING);
            reset_player <= (next_state == ST_ADVANCE);
            if (state == ST_ADVANCE) begin
                if (current_song == SONG_W'(NUM_SONGS-1)) begin
                    current_song <= '0;
                end else begin
                    current_song <= current_song + 1'b1;
                end
            end
        end
    end

    // ---------------- frame sync ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            new_frame_d          <= 1'b0;
            generate_next_sample <= 1'b0;
        end else begin
            new_frame_d          <= new_frame;
            generate_next_sample <= new_frame & ~new_frame_d;
        end
    end

    // ---------------- beat ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
            beat     <= 1'b0;
        end else begin
            beat <= 1'b0;
            if (reset_player) begin
                beat_cnt <= '0;
            end else if (generate_next_sample && play) begin
                if (beat_cnt == BEAT_W'(BEAT_COUNT-1)) begin
                    beat_cnt <= '0;
                    beat     <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- mixer ----------------
    sample_mixer #(
        .NUM_VOICES (NUM_VOICES),
        .SAMPLE_W   (SAMPLE_W)
    ) u_mixer (
        .clk           (clk),
        .reset         (reset),
        .voice_samples (voice_samples),
        .voice_gain    (voice_gain),
        .sample_ready  (sample_ready),
        .pending       (pending)
    );

    // ---------------- output buffer ----------------
    // A frame reads the old pending value on the same edge the mixer writes a
    // new one, so a coincident sample_ready keeps valid set for the new mix.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_out <= '0;
            valid      <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (generate_next_sample) begin
                if (!play) begin
                    sample_out <= '0;
                end else if (valid) begin
                    sample_out <= pending;
                end else begin
                    underrun <= 1'b1;
                end
            end
            if (sample_ready) begin
                valid <= 1'b1;
            end else if (generate_next_sample && play) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_poly_music_core.sv
// Directed testbench for poly_music_core (BEAT_COUNT = 100).
module tb_poly_music_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        play_button = 1'b0;
    logic        next_button = 1'b0;
    logic        song_done = 1'b0;
    logic        new_frame = 1'b0;
    logic [47:0] voice_samples = '0;
    logic [5:0]  voice_gain = '0;
    logic        sample_ready = 1'b0;
    logic        play;
    logic [1:0]  current_song;
    logic        reset_player;
    logic        beat;
    logic        generate_next_sample;
    logic [15:0] sample_out;
    logic        underrun;

    int checks = 0;
    int errors = 0;
    int beat_n = 0;
    int rp_n   = 0;
    int ur_n   = 0;
    int base;

    always #5 clk = ~clk;

    poly_music_core #(
        .NUM_SONGS  (4),
        .SONG_W     (2),
        .NUM_VOICES (3),
        .SAMPLE_W   (16),
        .BEAT_COUNT (100),
        .BEAT_W     (10)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .play_button          (play_button),
        .next_button          (next_button),
        .song_done            (song_done),
        .new_frame            (new_frame),
        .voice_samples        (voice_samples),
        .voice_gain           (voice_gain),
        .sample_ready         (sample_ready),
        .play                 (play),
        .current_song         (current_song),
        .reset_player         (reset_player),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .sample_out           (sample_out),
        .underrun             (underrun)
    );

    always @(posedge clk) begin
        if (beat)         beat_n <= beat_n + 1;
        if (reset_player) rp_n   <= rp_n + 1;
        if (underrun)     ur_n   <= ur_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic press_play();
        @(negedge clk) play_button = 1'b1;
        @(negedge clk) play_button = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_next();
        @(negedge clk) next_button = 1'b1;
        @(negedge clk) next_button = 1'b0;
        @(negedge clk);
    endtask

    task automatic frame();
        @(negedge clk) new_frame = 1'b1;
        repeat (2) @(negedge clk);
        new_frame = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_mix(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                            input logic [1:0] g0, input logic [1:0] g1, input logic [1:0] g2);
        @(negedge clk);
        voice_samples = {s2, s1, s0};
        voice_gain    = {g2, g1, g0};
        sample_ready  = 1'b1;
        @(negedge clk) sample_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_play", play, 0);
        check("rst_song", current_song, 0);
        check("rst_rp", reset_player, 0);
        check("rst_beat", beat, 0);
        check("rst_gns", generate_next_sample, 0);
        check("rst_out", sample_out, 0);
        check("rst_ur", underrun, 0);
        reset = 1'b0;
        @(negedge clk);

        // play then four nexts: wraps 1,2,3,0
        press_play();
        check("play_on", play, 1);
        base = rp_n;
        press_next();
        check("song_1", current_song, 1);
        check("after_next_paused", play, 0);
        press_next();
        check("song_2", current_song, 2);
        press_next();
        check("song_3", current_song, 3);
        press_next();
        check("song_wrap0", current_song, 0);
        check("rp_pulses4", rp_n - base, 4);
        check("play_off", play, 0);

        // next and song_done together while playing: one advance
        press_play();
        base = rp_n;
        @(negedge clk) begin next_button = 1'b1; song_done = 1'b1; end
        @(negedge clk) begin next_button = 1'b0; song_done = 1'b0; end
        repeat (2) @(negedge clk);
        check("coinc_song", current_song, 1);
        check("coinc_rp", rp_n - base, 1);

        // song_done while paused is ignored
        base = rp_n;
        @(negedge clk) song_done = 1'b1;
        @(negedge clk) song_done = 1'b0;
        repeat (2) @(negedge clk);
        check("done_paused_song", current_song, 1);
        check("done_paused_rp", rp_n - base, 0);

        // beats: 250 frames -> 2, paused 50 -> 0, resumed 49 -> 0, 50th -> 1
        press_play();
        base = beat_n;
        repeat (250) frame();
        check("beats_250", beat_n - base, 2);
        press_play();
        check("paused", play, 0);
        base = beat_n;
        repeat (50) frame();
        check("beats_paused", beat_n - base, 0);
        press_play();
        base = beat_n;
        repeat (49) frame();
        check("beats_held49", beat_n - base, 0);
        frame();
        check("beats_held50", beat_n - base, 1);

        // mixing and saturation
        load_mix(16'h7000, 16'h7000, 16'h7000, 2'd3, 2'd3, 2'd3);
        frame();
        check("mix_sat_pos", sample_out, 16'h7FFF);
        load_mix(16'h9000, 16'h9000, 16'h9000, 2'd3, 2'd3, 2'd3);
        frame();
        check("mix_sat_neg", sample_out, 16'h8000);
        load_mix(16'h4000, 16'h4000, 16'h7FFF, 2'd1, 2'd2, 2'd0);
        frame();
        check("mix_gain", sample_out, 16'h3000);

        // underrun
        load_mix(16'h1234, 16'h0000, 16'h0000, 2'd3, 2'd0, 2'd0);
        base = ur_n;
        frame();
        check("ur_first_out", sample_out, 16'h1234);
        check("ur_first", ur_n - base, 0);
        frame();
        check("ur_second", ur_n - base, 1);
        check("ur_second_out", sample_out, 16'h1234);
        press_play();
        base = ur_n;
        frame();
        check("paused_out", sample_out, 0);
        check("paused_ur", ur_n - base, 0);

        // mix write coincident with frame pulse
        press_play();
        load_mix(16'h0100, 16'h0000, 16'h0000, 2'd3, 2'd0, 2'd0);
        base = ur_n;
        @(negedge clk) new_frame = 1'b1;
        @(negedge clk) begin
            voice_samples = {16'h0000, 16'h0000, 16'h0200};
            sample_ready  = 1'b1;
        end
        @(negedge clk) begin sample_ready = 1'b0; new_frame = 1'b0; end
        repeat (2) @(negedge clk);
        check("coinc_old", sample_out, 16'h0100);
        frame();
        check("coinc_new", sample_out, 16'h0200);
        check("coinc_ur", ur_n - base, 0);

        // reset mid-playing with pending valid
        load_mix(16'h0555, 16'h0000, 16'h0000, 2'd3, 2'd0, 2'd0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("mid_rst_play", play, 0);
        check("mid_rst_song", current_song, 0);
        check("mid_rst_out", sample_out, 0);
        check("mid_rst_rp", reset_player, 0);
        check("mid_rst_ur", underrun, 0);
        reset = 1'b0;
        base = ur_n;
        frame();
        check("post_rst_ur", ur_n - base, 0);
        check("post_rst_out", sample_out, 0);
        check("post_rst_play", play, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
